// File: rtl/instruction_fetch_unit_pkg.sv
// ============================================================================
// Module      : instruction_fetch_unit_pkg
// Description : Shared definitions for the instruction fetch unit: opcode
//               constant used for bubbles, instruction field widths and
//               the fetch FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Opcode used to fill the instruction register on reset and redirect.
`ifndef NOP
`define NOP 4'h0
`endif

package instruction_fetch_unit_pkg;

  localparam int OPCODE_W  = 4;
  localparam int OPERAND_W = 24;

  // Fetch FSM: normal fetch, stalled, or one cycle after a redirect.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_BUBBLE = 2'd2
  } ifu_state_e;

endpackage : instruction_fetch_unit_pkg

`default_nettype wire

// File: rtl/instruction_fetch_unit_pc_reg.sv
// ============================================================================
// Module      : ifu_pc_reg
// Description : Program counter register with next-PC selection
//               (reset / redirect target / hold / increment).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_pc_reg #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next-PC mux: a redirect beats a stall; increment wraps naturally.
  always_comb begin
    pc_d = pc_q + ADDR_W'(1);
    if (branch_taken) begin
      pc_d = branch_target;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : ifu_pc_reg

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage in front of a combinational program ROM. Owns the
//               PC, registers the ROM word into the instruction register and
//               inserts one NOP bubble per taken branch/jump redirect.
//               Optional valid-fetch counter enabled by IFU_PERF_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NOP
`define NOP 4'h0
`endif

module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 28,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  input  logic [INSTR_W-1:0] iRomData,
  output logic [ADDR_W-1:0]  oRomAddress,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oPC,
  output logic               oValid,
  output logic [31:0]        oFetchCount
);

  localparam logic [INSTR_W-1:0] NOP_WORD = {`NOP, {(INSTR_W-OPCODE_W){1'b0}}};

  ifu_state_e         state_q;
  ifu_state_e         state_d;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic               valid_q;

  ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (Clock),
    .rst           (Reset),
    .stall         (iStall),
    .branch_taken  (iBranchTaken),
    .branch_target (iBranchTarget),
    .pc            (pc)
  );

  // Next-state logic: redirect -> BUBBLE, stall -> HOLD, else RUN.
  always_comb begin
    state_d = state_q;
    if (iBranchTaken) begin
      state_d = ST_BUBBLE;
    end else if (iStall) begin
      state_d = ST_HOLD;
    end else begin
      state_d = ST_RUN;
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction register: wrong-path word is dropped on redirect, all
  // state holds on stall, otherwise capture the ROM word and its address.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      instr_q    <= NOP_WORD;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else if (iBranchTaken) begin
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
    end else if (!iStall) begin
      instr_q    <= iRomData;
      instr_pc_q <= pc;
      valid_q    <= 1'b1;
    end
  end

`ifdef IFU_PERF_COUNT_EN
  logic        fetch_fire;
  logic [31:0] fetch_count_q;

  assign fetch_fire = !iBranchTaken && !iStall;

  // Count edges that load a valid instruction; wraps at 2^32.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_count_q <= '0;
    end else if (fetch_fire) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign oFetchCount = fetch_count_q;
`else
  assign oFetchCount = '0;
`endif

  assign oRomAddress  = pc;
  assign oInstruction = instr_q;
  assign oPC          = instr_pc_q;
  assign oValid       = valid_q;

endmodule : instruction_fetch_unit

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed, table-driven bench for instruction_fetch_unit with a
//               behavioural ROM. Counter expectations follow IFU_PERF_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

  localparam logic [27:0] NOP_WORD = 28'h0000000;

  logic        Clock;
  logic        Reset;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic [27:0] iRomData;
  logic [15:0] oRomAddress;
  logic [27:0] oInstruction;
  logic [15:0] oPC;
  logic        oValid;
  logic [31:0] oFetchCount;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_addr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  instruction_fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (28),
    .RESET_PC (16'h0000)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iStall        (iStall),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .iRomData      (iRomData),
    .oRomAddress   (oRomAddress),
    .oInstruction  (oInstruction),
    .oPC           (oPC),
    .oValid        (oValid),
    .oFetchCount   (oFetchCount)
  );

  // Distinct word per address so every fetch is identifiable.
  function automatic logic [27:0] rom(input logic [15:0] a);
    return {4'hA ^ a[15:12], 8'h3C, a};
  endfunction

  function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef IFU_PERF_COUNT_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  assign iRomData = rom(oRomAddress);

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic stall, input logic br,
                     input logic [15:0] tgt, input logic v, input logic [15:0] pc,
                     input logic [15:0] addr, input logic [31:0] cnt);
    vec_t t;
    t.rst = rst; t.stall = stall; t.br = br; t.tgt = tgt;
    t.e_valid = v; t.e_pc = pc; t.e_addr = addr; t.e_cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic rst, input logic stall, input logic br,
                       input logic [15:0] tgt);
    Reset = rst; iStall = stall; iBranchTaken = br; iBranchTarget = tgt;
  endtask

  task automatic check_all(input int idx, input logic v, input logic [15:0] pc,
                           input logic [15:0] addr, input logic [31:0] cnt);
    check("valid", idx, 32'(oValid), 32'(v));
    check("pc", idx, 32'(oPC), 32'(pc));
    check("instr", idx, 32'(oInstruction), 32'(v ? rom(pc) : NOP_WORD));
    check("rom_addr", idx, 32'(oRomAddress), 32'(addr));
    check("fetch_count", idx, oFetchCount, exp_cnt(cnt));
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 16'h0000);

    //   rst stall br  tgt       v    pc       addr     cnt
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);   // reset
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);   // reset 2nd cycle
    add(0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0001, 1);   // A @0
    add(0, 0, 0, 16'h0000, 1, 16'h0001, 16'h0002, 2);   // B @1
    add(0, 1, 0, 16'h0000, 1, 16'h0001, 16'h0002, 2);   // stall x3 holds B
    add(0, 1, 0, 16'h0000, 1, 16'h0001, 16'h0002, 2);
    add(0, 1, 0, 16'h0000, 1, 16'h0001, 16'h0002, 2);
    add(0, 0, 0, 16'h0000, 1, 16'h0002, 16'h0003, 3);   // C @2
    add(0, 0, 0, 16'h0000, 1, 16'h0003, 16'h0004, 4);
    add(0, 0, 0, 16'h0000, 1, 16'h0004, 16'h0005, 5);   // five fetches
    add(0, 0, 0, 16'h0000, 1, 16'h0005, 16'h0006, 6);   // oPC=5
    add(0, 0, 1, 16'h0001, 0, 16'h0005, 16'h0001, 6);   // redirect -> bubble
    add(0, 0, 0, 16'h0000, 1, 16'h0001, 16'h0002, 7);   // ROM[1]
    add(0, 0, 0, 16'h0000, 1, 16'h0002, 16'h0003, 8);   // ROM[2]
    add(0, 1, 1, 16'h0007, 0, 16'h0002, 16'h0007, 8);   // branch beats stall
    add(0, 1, 0, 16'h0000, 0, 16'h0002, 16'h0007, 8);   // bubble held by stall
    add(0, 0, 0, 16'h0000, 1, 16'h0007, 16'h0008, 9);   // ROM[7]
    add(0, 0, 1, 16'hFFFF, 0, 16'h0007, 16'hFFFF, 9);   // jump to top
    add(0, 0, 0, 16'h0000, 1, 16'hFFFF, 16'h0000, 10);  // ROM[FFFF], wrap
    add(0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0001, 11);  // ROM[0]
    add(0, 0, 1, 16'h0001, 0, 16'h0000, 16'h0001, 11);  // self-loop target
    add(0, 0, 0, 16'h0000, 1, 16'h0001, 16'h0002, 12);
    add(0, 1, 0, 16'h0000, 1, 16'h0001, 16'h0002, 12);  // enter HOLD
    add(1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);   // reset mid-stall
    add(0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0001, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt);
      tick();
      check_all(i, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_addr, vecs[i].e_cnt);
    end

    // Back-to-back redirects: second branch arrives during the bubble.
    drive(1'b0, 1'b0, 1'b1, 16'h0010);
    tick();
    check_all(100, 1'b0, 16'h0000, 16'h0010, 1);
    drive(1'b0, 1'b1, 1'b1, 16'h0020);
    tick();
    check_all(101, 1'b0, 16'h0000, 16'h0020, 1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    check_all(102, 1'b1, 16'h0020, 16'h0021, 2);

    // Long stall: nothing moves for an arbitrary number of cycles.
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int k = 0; k < 20; k++) tick();
    check_all(103, 1'b1, 16'h0020, 16'h0021, 2);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    check_all(104, 1'b1, 16'h0021, 16'h0022, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_instruction_fetch_unit

`default_nettype wire
